// File: rtl/audio_fir_filter.sv
// Stereo boxcar/FIR filter for the codec line-in to headphone path.
// One shared multiplier walks the left then the right delay line, one tap per clock.
module audio_fir_filter #(
  parameter int TAPS = 16,
  parameter int COEF_W = 16,
  parameter logic [TAPS*COEF_W-1:0] COEFS = {TAPS{COEF_W'(16'h0800)}}
) (
  input  logic               clk_48,
  input  logic               rst,
  input  logic               new_sample,
  input  logic signed [15:0] in_l,
  input  logic signed [15:0] in_r,
  input  logic               filter_en,
  output logic signed [15:0] out_l,
  output logic signed [15:0] out_r,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int PW     = $clog2(TAPS);
  localparam int PROD_W = 16 + COEF_W;
  localparam int ACC_W  = PROD_W + PW;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef enum logic [1:0] {IDLE, MAC_L, MAC_R, DONE} state_t;

  state_t                    r_state;
  logic signed [15:0]        r_dl_l [TAPS];
  logic signed [15:0]        r_dl_r [TAPS];
  logic        [PW-1:0]      r_ptr;
  logic        [PW-1:0]      r_k;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [15:0]        r_res_l;
  logic signed [15:0]        r_res_r;

  logic signed [COEF_W-1:0]  w_h [TAPS];
  logic        [PW-1:0]      w_rd_idx;
  logic signed [15:0]        w_x;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic                      w_last_tap;

  for (genvar g = 0; g < TAPS; g++) begin : g_coef
    assign w_h[g] = COEFS[g*COEF_W +: COEF_W];
  end

  // r_ptr already points past the newest sample, so tap k reads x[n-k] at r_ptr-1-k.
  assign w_rd_idx   = r_ptr - PW'(1) - r_k;
  assign w_x        = (r_state == MAC_R) ? r_dl_r[w_rd_idx] : r_dl_l[w_rd_idx];
  assign w_coef     = w_h[r_k];
  assign w_prod     = w_x * w_coef;
  assign w_acc_next = r_acc + $signed({{PW{w_prod[PROD_W-1]}}, w_prod});
  assign w_last_tap = (r_k == PW'(TAPS - 1));
  assign busy       = (r_state != IDLE);

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> 15;
    if (s > SAT_MAX)      return 16'sh7FFF;
    else if (s < SAT_MIN) return 16'sh8000;
    else                  return s[15:0];
  endfunction

  always_ff @(posedge clk_48) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_res_l   <= '0;
      r_res_r   <= '0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        r_dl_l[i] <= '0;
        r_dl_r[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      // Any strobe outside IDLE, including the DONE cycle, is dropped.
      if (new_sample && r_state != IDLE) overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (new_sample) begin
            r_dl_l[r_ptr] <= in_l;
            r_dl_r[r_ptr] <= in_r;
            r_ptr         <= r_ptr + PW'(1);
            r_k           <= '0;
            r_acc         <= '0;
            if (filter_en) begin
              r_state <= MAC_L;
            end else begin
              r_res_l <= in_l;
              r_res_r <= in_r;
              r_state <= DONE;
            end
          end
        end
        MAC_L: begin
          r_k   <= r_k + PW'(1);
          r_acc <= w_acc_next;
          if (w_last_tap) begin
            r_res_l <= sat16(w_acc_next);
            r_acc   <= '0;
            r_state <= MAC_R;
          end
        end
        MAC_R: begin
          r_k   <= r_k + PW'(1);
          r_acc <= w_acc_next;
          if (w_last_tap) begin
            r_res_r <= sat16(w_acc_next);
            r_acc   <= '0;
            r_state <= DONE;
          end
        end
        DONE: begin
          out_l     <= r_res_l;
          out_r     <= r_res_r;
          out_valid <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_fir_filter.sv
// Scoreboard bench for audio_fir_filter: a default boxcar instance plus a saturating-table instance.
`timescale 1ns/1ps
module tb_audio_fir_filter;

  typedef struct {
    string name;
    int    l;
    int    r;
    int    cyc;
  } exp_t;

  logic clk_48 = 1'b0;
  logic rst, ns0, ns1, filter_en;
  logic signed [15:0] in_l, in_r;
  logic signed [15:0] outl0, outr0, outl1, outr1;
  logic val0, val1, busy0, busy1, ov0, ov1;

  int cyc = 0;
  int nAssert = 0;
  int nFail = 0;
  exp_t q0[$];
  exp_t q1[$];

  // floor(k * 1000 * 2048 / 32768) for k = 1..16, then the full window
  int stepTab [17] = '{62, 125, 187, 250, 312, 375, 437, 500, 562, 625,
                       687, 750, 812, 875, 937, 1000, 1000};

  audio_fir_filter u_dut (
    .clk_48(clk_48), .rst(rst), .new_sample(ns0), .in_l(in_l), .in_r(in_r),
    .filter_en(filter_en), .out_l(outl0), .out_r(outr0), .out_valid(val0),
    .busy(busy0), .overrun(ov0)
  );

  audio_fir_filter #(.COEFS({16{16'h7FFF}})) u_sat (
    .clk_48(clk_48), .rst(rst), .new_sample(ns1), .in_l(in_l), .in_r(in_r),
    .filter_en(filter_en), .out_l(outl1), .out_r(outr1), .out_valid(val1),
    .busy(busy1), .overrun(ov1)
  );

  always #10.417 clk_48 = ~clk_48;

  always @(posedge clk_48) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    nAssert++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Caller sits at a negedge; the strobe is high for exactly the following posedge.
  task automatic applyStimulus(input bit toSat, input int l, input int r, input bit fen,
                               input bit push, input string name, input int el, input int er);
    exp_t e;
    in_l      = 16'(l);
    in_r      = 16'(r);
    filter_en = fen;
    if (toSat) ns1 = 1'b1; else ns0 = 1'b1;
    if (push) begin
      e.name = name;
      e.l    = el;
      e.r    = er;
      e.cyc  = cyc + (fen ? 34 : 2);
      if (toSat) q1.push_back(e); else q0.push_back(e);
    end
    @(negedge clk_48);
    ns0 = 1'b0;
    ns1 = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(negedge clk_48);
    rst = 1'b0;
    @(negedge clk_48);
  endtask

  // Monitor for the default-coefficient instance: every out_valid pops one expectation.
  always @(negedge clk_48) begin
    if (val0) begin
      if (q0.size() == 0) begin
        checkOutput("unexpected_valid_main", 1, 0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        checkOutput({e.name, "_l"}, outl0, e.l);
        checkOutput({e.name, "_r"}, outr0, e.r);
        checkOutput({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  // Monitor for the all-0x7FFF instance.
  always @(negedge clk_48) begin
    if (val1) begin
      if (q1.size() == 0) begin
        checkOutput("unexpected_valid_sat", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        checkOutput({e.name, "_l"}, outl1, e.l);
        checkOutput({e.name, "_r"}, outr1, e.r);
        checkOutput({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1; ns0 = 1'b0; ns1 = 1'b0; filter_en = 1'b0; in_l = '0; in_r = '0;
    repeat (3) @(negedge clk_48);
    rst = 1'b0;
    @(negedge clk_48);

    checkOutput("reset_out_l", outl0, 0);
    checkOutput("reset_out_r", outr0, 0);
    checkOutput("reset_out_valid", val0, 0);
    checkOutput("reset_busy", busy0, 0);
    checkOutput("reset_overrun", ov0, 0);

    // DC step: output ramps as the boxcar window fills
    for (int k = 0; k < 17; k++) begin
      applyStimulus(0, 1000, 1000, 1, 1, $sformatf("step%0d", k), stepTab[k], stepTab[k]);
      repeat (40) @(negedge clk_48);
    end

    // Impulse on left only
    applyReset();
    for (int k = 0; k < 17; k++) begin
      applyStimulus(0, (k == 0) ? 32767 : 0, 0, 1, 1, $sformatf("imp%0d", k),
                    (k < 16) ? 2047 : 0, 0);
      repeat (40) @(negedge clk_48);
    end

    // Bypass, then filter over the stored history (right channel floors toward -inf)
    applyReset();
    applyStimulus(0, 16'h1234, -4661, 0, 1, "bypass", 4660, -4661);
    repeat (5) @(negedge clk_48);
    applyStimulus(0, 0, 0, 1, 1, "after_bypass", 291, -292);
    repeat (40) @(negedge clk_48);

    // Overrun: second strobe 10 cycles in is dropped
    applyReset();
    applyStimulus(0, 1000, 1000, 1, 1, "ovr_first", 62, 62);
    repeat (9) @(negedge clk_48);
    checkOutput("ovr_busy", busy0, 1);
    applyStimulus(0, 5000, 5000, 1, 0, "", 0, 0);
    checkOutput("ovr_flag_set", ov0, 1);
    repeat (40) @(negedge clk_48);
    checkOutput("ovr_flag_sticky", ov0, 1);
    applyStimulus(0, 0, 0, 1, 1, "ovr_hist", 62, 62);
    repeat (40) @(negedge clk_48);

    // Strobe landing on the DONE cycle is dropped too
    applyReset();
    checkOutput("ovr_cleared_by_reset", ov0, 0);
    applyStimulus(0, 2000, 2000, 1, 1, "done_first", 125, 125);
    repeat (32) @(negedge clk_48);
    applyStimulus(0, 8000, 8000, 1, 0, "", 0, 0);
    repeat (3) @(negedge clk_48);
    checkOutput("done_drop_overrun", ov0, 1);
    applyStimulus(0, 0, 0, 1, 1, "done_hist", 125, 125);
    repeat (40) @(negedge clk_48);

    // Reset mid-MAC aborts; a strobe during reset is ignored
    applyReset();
    applyStimulus(0, 32767, 0, 1, 0, "", 0, 0);
    repeat (19) @(negedge clk_48);
    rst = 1'b1; ns0 = 1'b1; in_l = 16'sd12345; in_r = 16'sd12345; filter_en = 1'b1;
    @(negedge clk_48);
    ns0 = 1'b0;
    @(negedge clk_48);
    rst = 1'b0;
    @(negedge clk_48);
    checkOutput("abort_out_l", outl0, 0);
    checkOutput("abort_out_r", outr0, 0);
    checkOutput("abort_busy", busy0, 0);
    checkOutput("abort_overrun", ov0, 0);
    repeat (40) @(negedge clk_48);
    for (int k = 0; k < 17; k++) begin
      applyStimulus(0, (k == 0) ? 32767 : 0, 0, 1, 1, $sformatf("imp2_%0d", k),
                    (k < 16) ? 2047 : 0, 0);
      repeat (40) @(negedge clk_48);
    end

    // Saturation with all taps at 0x7FFF: left pins at -32768, right at 32767
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1, -32768, 32767, 1, 1, $sformatf("sat%0d", k),
                    (k == 0) ? -32767 : -32768, (k == 0) ? 32766 : 32767);
      repeat (40) @(negedge clk_48);
    end

    for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk_48);
    checkOutput("pending_main", q0.size(), 0);
    checkOutput("pending_sat", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
